// File: rtl/uart_rx_drain_ctrl.sv
// Drains the UART RX FIFO and presents each {BE,OE,PE,FE,data} entry on a valid/ready
// stream, applying the drop/flush policy and keeping saturating per-error counters.
module uart_rx_drain_ctrl #(
  parameter int CNT_WIDTH      = 8,
  parameter int DROP_ERRORED   = 1,
  parameter int FLUSH_ON_BREAK = 1
) (
  input  logic                 UART_clk,
  input  logic                 rst,
  input  logic                 fifo_empty,
  output logic                 fifo_rd_en,
  input  logic [11:0]          fifo_rd_data,
  output logic [7:0]           m_data,
  output logic [3:0]           m_err,
  output logic                 m_valid,
  input  logic                 m_ready,
  input  logic                 flush_req,
  output logic                 busy,
  input  logic                 cnt_clr,
  output logic [CNT_WIDTH-1:0] be_cnt,
  output logic [CNT_WIDTH-1:0] oe_cnt,
  output logic [CNT_WIDTH-1:0] pe_cnt,
  output logic [CNT_WIDTH-1:0] fe_cnt
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_READ    = 3'd1,
    S_CAPTURE = 3'd2,
    S_HOLD    = 3'd3,
    S_FLUSH   = 3'd4
  } state_t;

  state_t               r_state;
  state_t               w_state_next;
  logic [7:0]           r_data;
  logic [3:0]           r_err;
  logic                 r_valid;
  logic [CNT_WIDTH-1:0] r_cnt [4];
  logic                 w_capture;
  logic                 w_break;
  logic                 w_drop;
  logic                 w_load;

  // A flush request in CAPTURE discards the pending entry before it is counted.
  assign w_capture = (r_state == S_CAPTURE) && !flush_req;
  assign w_break   = (FLUSH_ON_BREAK != 0) && fifo_rd_data[11];
  assign w_drop    = (DROP_ERRORED != 0) && (fifo_rd_data[9] || fifo_rd_data[8]);
  assign w_load    = w_capture && !w_break && !w_drop;

  always_ff @(posedge UART_clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    if (flush_req) begin
      w_state_next = S_FLUSH;
    end else begin
      case (r_state)
        S_IDLE:    if (!fifo_empty) w_state_next = S_READ;
        S_READ:    w_state_next = S_CAPTURE;
        S_CAPTURE: begin
          if (w_break)     w_state_next = S_FLUSH;
          else if (w_drop) w_state_next = S_IDLE;
          else             w_state_next = S_HOLD;
        end
        S_HOLD:    if (m_ready) w_state_next = S_IDLE;
        S_FLUSH:   if (fifo_empty) w_state_next = S_IDLE;
        default:   w_state_next = S_IDLE;
      endcase
    end
  end

  // Read strobe is gated by reset so no read leaks out while rst is held.
  always_comb begin
    fifo_rd_en = 1'b0;
    busy       = (r_state != S_IDLE);
    if (!rst && !fifo_empty) begin
      if (r_state == S_FLUSH) begin
        fifo_rd_en = 1'b1;
      end else if ((r_state == S_IDLE) && !flush_req) begin
        fifo_rd_en = 1'b1;
      end
    end
  end

  always_ff @(posedge UART_clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_err   <= '0;
    end else begin
      if (flush_req) begin
        r_valid <= 1'b0;
      end else if (w_load) begin
        r_valid <= 1'b1;
      end else if ((r_state == S_HOLD) && m_ready) begin
        r_valid <= 1'b0;
      end
      if (w_load) begin
        r_data <= fifo_rd_data[7:0];
        r_err  <= fifo_rd_data[11:8];
      end
    end
  end

  // Counter gi tracks flag bit fifo_rd_data[8+gi]: 0=FE 1=PE 2=OE 3=BE.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_cnt
      always_ff @(posedge UART_clk or posedge rst) begin
        if (rst) begin
          r_cnt[gi] <= '0;
        end else if (cnt_clr) begin
          r_cnt[gi] <= '0;
        end else if (w_capture && fifo_rd_data[8+gi] && (r_cnt[gi] != '1)) begin
          r_cnt[gi] <= r_cnt[gi] + 1'b1;
        end
      end
    end
  endgenerate

  assign m_data  = r_data;
  assign m_err   = r_err;
  assign m_valid = r_valid;
  assign fe_cnt  = r_cnt[0];
  assign pe_cnt  = r_cnt[1];
  assign oe_cnt  = r_cnt[2];
  assign be_cnt  = r_cnt[3];

endmodule

// File: tb/tb_uart_rx_drain_ctrl.sv
// Bench for uart_rx_drain_ctrl: two instances (default policy, and forwarding with 2-bit
// counters), each fed by a queue-based FIFO model; table vectors, corner sequences, random traffic.
module tb_uart_rx_drain_ctrl;

  logic        clk;
  logic        rst;

  logic        a_empty, a_rd_en, a_m_valid, a_m_ready, a_flush, a_busy, a_clr;
  logic [11:0] a_rd_data;
  logic [7:0]  a_m_data;
  logic [3:0]  a_m_err;
  logic [7:0]  a_be, a_oe, a_pe, a_fe;

  logic        b_empty, b_rd_en, b_m_valid, b_m_ready, b_flush, b_busy, b_clr;
  logic [11:0] b_rd_data;
  logic [7:0]  b_m_data;
  logic [3:0]  b_m_err;
  logic [1:0]  b_be, b_oe, b_pe, b_fe;

  uart_rx_drain_ctrl u_dut_a (
    .UART_clk(clk), .rst(rst), .fifo_empty(a_empty), .fifo_rd_en(a_rd_en),
    .fifo_rd_data(a_rd_data), .m_data(a_m_data), .m_err(a_m_err), .m_valid(a_m_valid),
    .m_ready(a_m_ready), .flush_req(a_flush), .busy(a_busy), .cnt_clr(a_clr),
    .be_cnt(a_be), .oe_cnt(a_oe), .pe_cnt(a_pe), .fe_cnt(a_fe)
  );

  uart_rx_drain_ctrl #(.CNT_WIDTH(2), .DROP_ERRORED(0), .FLUSH_ON_BREAK(1)) u_dut_b (
    .UART_clk(clk), .rst(rst), .fifo_empty(b_empty), .fifo_rd_en(b_rd_en),
    .fifo_rd_data(b_rd_data), .m_data(b_m_data), .m_err(b_m_err), .m_valid(b_m_valid),
    .m_ready(b_m_ready), .flush_req(b_flush), .busy(b_busy), .cnt_clr(b_clr),
    .be_cnt(b_be), .oe_cnt(b_oe), .pe_cnt(b_pe), .fe_cnt(b_fe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [11:0] entry;
    logic        exp_valid;
    logic [7:0]  exp_data;
    logic [3:0]  exp_err;
  } vec_t;

  vec_t        vecs [7];
  logic [11:0] fqa[$];
  logic [11:0] fqb[$];
  logic [11:0] acc_a[$];
  logic [11:0] acc_b[$];
  logic [11:0] exp_q[$];
  int          checks = 0;
  int          passes = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // One clock: FIFO model pops on a strobe seen at the edge, consumer side logs transfers.
  task automatic tick();
    logic pa, pb;
    #1;
    pa = a_rd_en;
    pb = b_rd_en;
    if (a_rd_en) chk("no_underflow_a", a_empty, 0);
    if (b_rd_en) chk("no_underflow_b", b_empty, 0);
    if (a_m_valid && a_m_ready) acc_a.push_back({a_m_err, a_m_data});
    if (b_m_valid && b_m_ready) acc_b.push_back({b_m_err, b_m_data});
    @(posedge clk);
    #1;
    if (pa && fqa.size() > 0) a_rd_data = fqa.pop_front();
    if (pb && fqb.size() > 0) b_rd_data = fqb.pop_front();
    a_empty = (fqa.size() == 0);
    b_empty = (fqb.size() == 0);
    @(negedge clk);
  endtask

  task automatic push_a(input logic [11:0] e);
    fqa.push_back(e);
    a_empty = 1'b0;
  endtask

  task automatic push_b(input logic [11:0] e);
    fqb.push_back(e);
    b_empty = 1'b0;
  endtask

  initial begin
    int          oe_e, pe_e, fe_e, be_e;
    int          oe_m, pe_m, fe_m;
    int          n_pushed;
    logic        done, prev_hold;
    logic [12:0] prev_word;
    logic [2:0]  fl;
    logic [7:0]  by;
    logic [11:0] bp_exp [3];

    vecs[0] = '{12'h0A5, 1'b1, 8'hA5, 4'h0};
    vecs[1] = '{12'h23C, 1'b0, 8'h00, 4'h0};
    vecs[2] = '{12'h15A, 1'b0, 8'h00, 4'h0};
    vecs[3] = '{12'h4C3, 1'b1, 8'hC3, 4'h4};
    vecs[4] = '{12'h6FF, 1'b0, 8'h00, 4'h0};
    vecs[5] = '{12'h000, 1'b1, 8'h00, 4'h0};
    vecs[6] = '{12'h47E, 1'b1, 8'h7E, 4'h4};
    bp_exp[0] = 12'h0A1; bp_exp[1] = 12'h0B2; bp_exp[2] = 12'h0C3;

    rst = 1'b1;
    a_empty = 1'b1; a_rd_data = '0; a_m_ready = 1'b0; a_flush = 1'b0; a_clr = 1'b0;
    b_empty = 1'b1; b_rd_data = '0; b_m_ready = 1'b0; b_flush = 1'b0; b_clr = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_outputs_a", {a_m_valid, a_rd_en, a_busy, a_m_data, a_m_err, a_be, a_oe, a_pe, a_fe}, 0);
    rst = 1'b0;
    tick();

    // Single clean byte: m_valid rises on the third edge after empty falls.
    a_m_ready = 1'b1;
    push_a(12'h0A5);
    tick(); tick();
    chk("latency_not_early", a_m_valid, 0);
    tick();
    chk("latency_valid", a_m_valid, 1);
    chk("latency_data", a_m_data, 8'hA5);
    chk("latency_err", a_m_err, 4'h0);
    tick();

    oe_e = 0; pe_e = 0; fe_e = 0; be_e = 0;
    for (int i = 0; i < 7; i++) begin
      push_a(vecs[i].entry);
      tick(); tick(); tick();
      chk($sformatf("vec%0d_valid", i), a_m_valid, vecs[i].exp_valid);
      if (vecs[i].exp_valid) begin
        chk($sformatf("vec%0d_data", i), a_m_data, vecs[i].exp_data);
        chk($sformatf("vec%0d_err", i), a_m_err, vecs[i].exp_err);
      end
      tick();
      chk($sformatf("vec%0d_idle", i), a_busy, 0);
      be_e += int'(vecs[i].entry[11]); oe_e += int'(vecs[i].entry[10]);
      pe_e += int'(vecs[i].entry[9]);  fe_e += int'(vecs[i].entry[8]);
    end
    chk("tbl_cnts", {a_be, a_oe, a_pe, a_fe}, {8'(be_e), 8'(oe_e), 8'(pe_e), 8'(fe_e)});

    // Break entry flushes everything queued behind it.
    acc_a.delete();
    push_a(12'h011); push_a(12'h800); push_a(12'h022); push_a(12'h033);
    repeat (30) tick();
    chk("brk_delivered_count", acc_a.size(), 1);
    chk("brk_delivered_byte", acc_a[0], 12'h011);
    chk("brk_fifo_drained", {a_empty, 32'(fqa.size())}, {1'b1, 32'd0});
    chk("brk_be_cnt", a_be, 1);
    chk("brk_idle", a_busy, 0);

    // Backpressure: one read only, byte held stable, then in-order release.
    acc_a.delete();
    a_m_ready = 1'b0;
    push_a(12'h0A1); push_a(12'h0B2); push_a(12'h0C3);
    repeat (10) tick();
    chk("bp_valid", a_m_valid, 1);
    chk("bp_data", a_m_data, 8'hA1);
    chk("bp_one_read", fqa.size(), 2);
    repeat (5) tick();
    chk("bp_data_stable", a_m_data, 8'hA1);
    a_m_ready = 1'b1;
    repeat (20) tick();
    chk("bp_count", acc_a.size(), 3);
    for (int i = 0; i < 3; i++) chk($sformatf("bp_order%0d", i), acc_a[i], bp_exp[i]);

    // flush_req while holding a byte.
    a_m_ready = 1'b0;
    push_a(12'h055); push_a(12'h066);
    repeat (5) tick();
    chk("fl_hold_valid", a_m_valid, 1);
    a_flush = 1'b1;
    tick();
    a_flush = 1'b0;
    chk("fl_valid_dropped", a_m_valid, 0);
    repeat (3) tick();
    chk("fl_fifo_empty", {a_empty, 32'(fqa.size())}, {1'b1, 32'd0});
    chk("fl_idle", a_busy, 0);
    a_m_ready = 1'b1;

    // flush_req with an already empty FIFO: one FLUSH cycle, then IDLE.
    a_flush = 1'b1;
    tick();
    a_flush = 1'b0;
    chk("fl_empty_busy", a_busy, 1);
    tick();
    chk("fl_empty_exit", a_busy, 0);

    a_clr = 1'b1;
    tick();
    a_clr = 1'b0;
    chk("clr_all", {a_be, a_oe, a_pe, a_fe}, 0);

    // Random traffic (no breaks) against a stream-level model: PE/FE entries vanish, the rest arrive in order.
    acc_a.delete(); exp_q.delete();
    oe_m = 0; pe_m = 0; fe_m = 0; n_pushed = 0; done = 1'b0; prev_hold = 1'b0; prev_word = '0;
    for (int cyc = 0; cyc < 4000 && !done; cyc++) begin
      if (prev_hold) chk("rand_hold_stable", {a_m_valid, a_m_err, a_m_data}, prev_word);
      a_m_ready = 1'($urandom_range(0, 1));
      if (n_pushed < 60 && $urandom_range(0, 2) == 0) begin
        fl = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
        by = 8'($urandom);
        push_a({1'b0, fl, by});
        if (!(fl[1] || fl[0])) exp_q.push_back({1'b0, fl, by});
        oe_m += int'(fl[2]); pe_m += int'(fl[1]); fe_m += int'(fl[0]);
        n_pushed++;
      end
      prev_hold = a_m_valid && !a_m_ready;
      prev_word = {1'b1, a_m_err, a_m_data};
      tick();
      done = (n_pushed == 60) && (fqa.size() == 0) && !a_busy && !a_m_valid;
    end
    if (!done) chk("rand_timeout", done, 1);
    chk("rand_count", acc_a.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < acc_a.size(); i++)
      chk($sformatf("rand_byte%0d", i), acc_a[i], exp_q[i]);
    chk("rand_cnts", {a_oe, a_pe, a_fe},
        {8'((oe_m > 255) ? 255 : oe_m), 8'((pe_m > 255) ? 255 : pe_m), 8'((fe_m > 255) ? 255 : fe_m)});

    // Asynchronous reset while in READ.
    a_m_ready = 1'b1;
    push_a(12'h077); push_a(12'h088);
    tick();
    rst = 1'b1;
    #1;
    chk("rst_mid_read_outputs", {a_m_valid, a_rd_en, a_busy, a_m_data, a_m_err, a_be, a_oe, a_pe, a_fe}, 0);
    tick();
    chk("rst_no_read", fqa.size(), 1);
    rst = 1'b0;
    acc_a.delete();
    repeat (8) tick();
    chk("rst_recover", {32'(acc_a.size()), acc_a[0]}, {32'd1, 12'h088});

    // Forwarding policy and 2-bit saturation on the second instance.
    b_m_ready = 1'b1;
    push_b(12'h23C);
    tick(); tick(); tick();
    chk("fwd_valid", b_m_valid, 1);
    chk("fwd_data", b_m_data, 8'h3C);
    chk("fwd_err", b_m_err, 4'b0010);
    chk("fwd_pe_cnt", b_pe, 1);
    tick();
    for (int i = 0; i < 5; i++) push_b(12'h1F0 + 12'(i));
    repeat (25) tick();
    chk("sat_delivered", acc_b.size(), 6);
    chk("sat_fe_cnt", b_fe, 3);
    push_b(12'h1F6);
    tick(); tick();
    b_clr = 1'b1;
    tick();
    b_clr = 1'b0;
    chk("clr_beats_inc_fe", b_fe, 0);
    chk("clr_pe", b_pe, 0);
    repeat (3) tick();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
